// File: rtl/pipelined_addsub.sv
// WIDTH-bit adder/subtractor pipelined in CHUNK-bit slices; the carry ripples one slice per stage.
// The whole pipeline advances together on adv = ~out_valid | out_ready, so bubbles are kept.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_STAGES = WIDTH / CHUNK;

    // Handshake: a beat is accepted on in_valid & in_ready and a result leaves on
    // out_valid & out_ready; in_ready never looks at in_valid.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH-1:0] ri;
        logic [WIDTH-1:0] rn;
        logic             ci;
        logic             vi;
        logic [CHUNK:0]   s;

        if (k == 0) begin : g_first
            // B is inverted once on entry, so sub needs no further travel.
            assign ai = a;
            assign bi = sub ? ~b : b;
            assign ri = '0;
            assign ci = sub ? 1'b1 : cin;
            assign vi = in_valid;
        end else begin : g_next
            assign ai = g_stage[k-1].g_mid.a_q;
            assign bi = g_stage[k-1].g_mid.b_q;
            assign ri = g_stage[k-1].g_mid.r_q;
            assign ci = g_stage[k-1].g_mid.c_q;
            assign vi = g_stage[k-1].g_mid.v_q;
        end

        assign s = {1'b0, ai[k*CHUNK +: CHUNK]} + {1'b0, bi[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, ci};

        always_comb begin
            rn = ri;
            rn[k*CHUNK +: CHUNK] = s[CHUNK-1:0];
        end

        if (k < NUM_STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] r_q;
            logic             c_q;
            logic             v_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    r_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= ai;
                    b_q <= bi;
                    r_q <= rn;
                    c_q <= s[CHUNK];
                    v_q <= vi;
                end
            end
        end else begin : g_last
            // Carry into the MSB recovered from the MSB sum bit and its operands.
            logic cmsb;
            assign cmsb = s[CHUNK-1] ^ ai[WIDTH-1] ^ bi[WIDTH-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (adv) begin
                    out_valid <= vi;
                    sum       <= rn;
                    cout      <= s[CHUNK];
                    ovf       <= s[CHUNK] ^ cmsb;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (16-bit, 4-bit slices) plus a single-slice instance for the 1-stage case.
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready1;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_valid1;
    logic        out_ready;
    logic [15:0] sum;
    logic [15:0] sum1;
    logic        cout;
    logic        cout1;
    logic        ovf;
    logic        ovf1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rx_cnt = 0;
    int first_rx = 0;
    int last_rx = 0;
    bit sb_on = 1'b0;
    logic [17:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_addsub #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: {cout, ovf, sum}
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [16:0] t;
        logic [15:0] be;
        logic        mo;
        be = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, be} + {16'd0, (msub ? 1'b1 : mcin)};
        mo = (ma[15] == be[15]) && (t[15] != ma[15]);
        return {t[16], mo, t[15:0]};
    endfunction

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (~out_valid | out_ready)});
            if (sb_on) begin
                if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", {14'd0, cout, ovf, sum}, 32'hFFFF_FFFF);
                    end else begin
                        chk("stream_result", {14'd0, cout, ovf, sum}, {14'd0, exp_q.pop_front()});
                    end
                    rx_cnt++;
                    if (rx_cnt == 1) first_rx = cyc;
                    last_rx = cyc;
                end
            end
        end
    end

    // driver tasks
    task automatic send_vec(input vec_t v);
        int n;
        @(posedge clk); #1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("one_stage_valid", {31'd0, out_valid1}, 32'd1);
                chk("one_stage_result", {14'd0, cout1, ovf1, sum1}, {14'd0, v.cout, v.ovf, v.sum});
            end
        end while (!out_valid && n < 10);
        chk("latency", n, 4);
        chk("vec_sum", {16'd0, sum}, {16'd0, v.sum});
        chk("vec_cout", {31'd0, cout}, {31'd0, v.cout});
        chk("vec_ovf", {31'd0, ovf}, {31'd0, v.ovf});
    endtask

    task automatic rand_beat();
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic run_stream(input int n, input bit rand_rdy);
        int  sent;
        int  budget;
        bit  acc;
        sent = 0;
        rx_cnt = 0;
        @(posedge clk); #1;
        sb_on = 1'b1;
        rand_beat();
        in_valid = 1'b1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        while (sent < n) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < n) rand_beat();
                else in_valid = 1'b0;
            end
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("rx_count", rx_cnt, n);
        @(posedge clk); #1;
        sb_on = 1'b0;
    endtask

    task automatic fill(input int n, input bit rdy);
        out_ready = rdy;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a = 16'h1000 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_sum"}, {16'd0, sum}, 32'd0);
        chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[10] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // directed vectors
        for (int i = 0; i < 11; i++) send_vec(vecs[i]);

        // back-to-back stream, always ready
        run_stream(100, 1'b0);
        chk("b2b_span", last_rx - first_rx, 99);

        // random backpressure
        run_stream(500, 1'b1);

        // full pipeline stall holds, then drains in order without loss
        fill(6, 1'b0);
        @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_sum", {16'd0, sum}, 32'h1001);
        @(negedge clk);
        chk("stall_hold_sum", {16'd0, sum}, 32'h1001);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_sum", {16'd0, sum}, 32'h1001 + i);
        end
        @(negedge clk);
        chk("drain_done", {31'd0, out_valid}, 32'd0);

        // reset asserted mid-stall
        fill(6, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero_outputs("rst_stall");
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_stall_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("rst_stall_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // reset with three beats in flight
        fill(3, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero_outputs("rst_flight");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_flight_no_stale", {31'd0, out_valid}, 32'd0);
        end
        send_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
